// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding unit for a 5-stage in-order pipeline.
//
// Keeps shadow copies (EX, MEM, WB) of the destination information held in the
// datapath pipeline registers. It uses them to pick EX operand sources and to
// stall on hazards that forwarding cannot cover.
//
// Optional feature macro: FORWARD_PATH_EN
//   defined   : ForwardA/ForwardB select bypass paths. Only load-use stalls.
//   undefined : ForwardA/ForwardB are tied to 00. Any EX/MEM producer of a used
//               source stalls. WB is covered by a write-before-read register file.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   ID_Rs, ID_Rt               source registers of the instruction in ID
//   ID_UseRs, ID_UseRt         the ID instruction really reads Rs / Rt
//   ID_Rd                      destination register of the ID instruction
//   ID_RegWrite, ID_MemRead    ID instruction writes a register / is a load
//   DC_stall                   data-cache miss; freezes the whole pipeline
//   ForwardA, ForwardB         EX operand select: 00 regfile, 01 WB_out, 10 MEM_ALUout
//   PC_Write, IFID_Write       0 holds PC and IF/ID
//   ID_flush                   1 turns the instruction entering ID/EX into a bubble
module hazard_forward_unit #(
  parameter int unsigned reg_size = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [reg_size-1:0] ID_Rs,
  input  logic [reg_size-1:0] ID_Rt,
  input  logic                ID_UseRs,
  input  logic                ID_UseRt,
  input  logic [reg_size-1:0] ID_Rd,
  input  logic                ID_RegWrite,
  input  logic                ID_MemRead,
  input  logic                DC_stall,
  output logic [1:0]          ForwardA,
  output logic [1:0]          ForwardB,
  output logic                PC_Write,
  output logic                IFID_Write,
  output logic                ID_flush
);

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                mem_read;
    logic [reg_size-1:0] rd;
  } slot_t;

  slot_t ex_q, mem_q, wb_q;

  // $0 is hardwired to zero, so a write to it never produces a value to bypass.
  function automatic logic slot_match(slot_t s, logic [reg_size-1:0] r);
    return s.valid & s.reg_write & (s.rd == r) & (s.rd != '0);
  endfunction

  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic hazard;
  logic dc_stall_eff;

  always_comb begin
    ex_rs  = slot_match(ex_q, ID_Rs);
    ex_rt  = slot_match(ex_q, ID_Rt);
    mem_rs = slot_match(mem_q, ID_Rs);
    mem_rt = slot_match(mem_q, ID_Rt);
  end

`ifdef FORWARD_PATH_EN
  // Only a load still in EX cannot be bypassed in time.
  assign hazard = ex_q.mem_read & ((ex_rs & ID_UseRs) | (ex_rt & ID_UseRt));
`else
  // No bypass network: wait until the producer reaches WB.
  assign hazard = ((ex_rs | mem_rs) & ID_UseRs) | ((ex_rt | mem_rt) & ID_UseRt);
`endif

  // A cache miss during reset must not hold the front end.
  assign dc_stall_eff = DC_stall & rst;
  assign PC_Write     = ~(dc_stall_eff | hazard);
  assign IFID_Write   = ~(dc_stall_eff | hazard);
  assign ID_flush     = hazard & ~dc_stall_eff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!DC_stall) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= '{valid: ~ID_flush, reg_write: ID_RegWrite, mem_read: ID_MemRead, rd: ID_Rd};
    end
  end

`ifdef FORWARD_PATH_EN
  // Younger (EX) producer wins. A load in EX has no ALU result to bypass.
  function automatic logic [1:0] fwd_sel(logic ex_m, logic ex_load, logic mem_m);
    if (ex_m && !ex_load) return 2'b10;
    else if (mem_m)       return 2'b01;
    else                  return 2'b00;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ForwardA <= 2'b00;
      ForwardB <= 2'b00;
    end else if (!DC_stall) begin
      if (ID_flush) begin
        ForwardA <= 2'b00;
        ForwardB <= 2'b00;
      end else begin
        ForwardA <= fwd_sel(ex_rs, ex_q.mem_read, mem_rs);
        ForwardB <= fwd_sel(ex_rt, ex_q.mem_read, mem_rt);
      end
    end
  end
`else
  assign ForwardA = 2'b00;
  assign ForwardB = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: the driver pushes hand-computed
// expectations per cycle; a monitor on the falling edge pops and compares.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] ID_Rs = '0, ID_Rt = '0, ID_Rd = '0;
  logic       ID_UseRs = 1'b0, ID_UseRt = 1'b0, ID_RegWrite = 1'b0, ID_MemRead = 1'b0;
  logic       DC_stall = 1'b0;
  logic [1:0] ForwardA, ForwardB;
  logic       PC_Write, IFID_Write, ID_flush;

  hazard_forward_unit #(.reg_size(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .ID_Rs      (ID_Rs),
    .ID_Rt      (ID_Rt),
    .ID_UseRs   (ID_UseRs),
    .ID_UseRt   (ID_UseRt),
    .ID_Rd      (ID_Rd),
    .ID_RegWrite(ID_RegWrite),
    .ID_MemRead (ID_MemRead),
    .DC_stall   (DC_stall),
    .ForwardA   (ForwardA),
    .ForwardB   (ForwardB),
    .PC_Write   (PC_Write),
    .IFID_Write (IFID_Write),
    .ID_flush   (ID_flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       pcw;
    logic       flush;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.nm, ".PC_Write"},   {1'b0, PC_Write},   {1'b0, e.pcw});
      chk({e.nm, ".IFID_Write"}, {1'b0, IFID_Write}, {1'b0, e.pcw});
      chk({e.nm, ".ID_flush"},   {1'b0, ID_flush},   {1'b0, e.flush});
      chk({e.nm, ".ForwardA"},   ForwardA,           e.fa);
      chk({e.nm, ".ForwardB"},   ForwardB,           e.fb);
    end
  end

  // One cycle: new inputs just after the rising edge. Expected values are the
  // combinational outputs for these inputs and the Forward values registered
  // at the previous edge.
  task automatic step(input string nm, input logic r, input int rs, input int rt,
                      input logic urs, input logic urt, input int rd, input logic rw,
                      input logic mr, input logic dcs, input logic e_pcw,
                      input logic e_flush, input logic [1:0] e_fa, input logic [1:0] e_fb);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    ID_Rs       = 5'(rs);
    ID_Rt       = 5'(rt);
    ID_UseRs    = urs;
    ID_UseRt    = urt;
    ID_Rd       = 5'(rd);
    ID_RegWrite = rw;
    ID_MemRead  = mr;
    DC_stall    = dcs;
    e.nm = nm; e.pcw = e_pcw; e.flush = e_flush; e.fa = e_fa; e.fb = e_fb;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with a cache miss present: stall must be ignored.
    step("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00);
    step("rst_hold2", 0, 3, 3, 1, 1, 3, 1, 1, 1, 1, 0, 2'b00, 2'b00);
`ifdef FORWARD_PATH_EN
    //    name        r  rs rt urs urt rd rw mr dcs pcw fl fa     fb
    step("add3",      1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("add4_3_5",  1, 3, 5, 1, 1, 4, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("exfwd",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00);
    step("add3b",     1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("unrel",     1, 1, 2, 1, 1, 11, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("sub6_2_3",  1, 2, 3, 1, 1, 6, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("memfwd",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01);
    step("lw7",       1, 1, 0, 1, 0, 7, 1, 1, 0, 1, 0, 2'b00, 2'b00);
    step("lu_stall",  1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    step("lu_go",     1, 7, 7, 1, 1, 8, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("lu_fwd",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b01);
    step("lw7_rs8",   1, 8, 0, 1, 0, 7, 1, 1, 0, 1, 0, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++)
      step("dc_freeze", 1, 7, 7, 1, 1, 8, 1, 0, 1, 0, 0, 2'b01, 2'b00);
    step("dc_rel",    1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 1, 2'b01, 2'b00);
    step("one_bub",   1, 7, 7, 1, 1, 8, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("dc_fwd",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b01);
    step("wr_r0",     1, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("rd_r0",     1, 0, 0, 1, 1, 9, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("lw_r0",     1, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 2'b00, 2'b00);
    step("rd_r0_lw",  1, 0, 0, 1, 1, 12, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("rd_r0_fwd", 1, 1, 2, 1, 1, 14, 1, 0, 0, 1, 0, 2'b00, 2'b00);
`else
    //    name        r  rs rt urs urt rd rw mr dcs pcw fl fa     fb
    step("add3",      1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("raw_ex",    1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    step("raw_mem",   1, 3, 1, 1, 1, 4, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    step("raw_go",    1, 3, 1, 1, 1, 4, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("wr_r0",     1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("rd_r0",     1, 0, 0, 1, 1, 9, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("rd_r0b",    1, 0, 0, 1, 1, 10, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("lw7",       1, 1, 0, 1, 0, 7, 1, 1, 0, 1, 0, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++)
      step("dc_freeze", 1, 7, 7, 1, 1, 8, 1, 0, 1, 0, 0, 2'b00, 2'b00);
    step("dc_rel_ex", 1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    step("dc_rel_mem",1, 7, 7, 1, 1, 8, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    step("dc_go",     1, 7, 7, 1, 1, 8, 1, 0, 0, 1, 0, 2'b00, 2'b00);
`endif
    // Async reset mid-stream: lw $5 in EX would stall this reader, and the
    // cache miss would freeze it, but reset clears both before any edge.
    step("lw5",       1, 1, 0, 1, 0, 5, 1, 1, 0, 1, 0, 2'b00, 2'b00);
    step("rst_async", 0, 5, 5, 1, 1, 13, 1, 0, 1, 1, 0, 2'b00, 2'b00);
    step("rst_rel",   1, 5, 5, 1, 1, 13, 1, 0, 0, 1, 0, 2'b00, 2'b00);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The module SHALL have parameter reg_size, default 5, meaning the register-specifier width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have ports ID_Rs and ID_Rt, input, reg_size bits each: source registers of the instruction in ID.
REQ-005 The module SHALL have ports ID_UseRs and ID_UseRt, input, 1 bit each: the ID instruction actually reads Rs or Rt.
REQ-006 The module SHALL have port ID_Rd, input, reg_size bits: destination register of the ID instruction.
REQ-007 The module SHALL have ports ID_RegWrite and ID_MemRead, input, 1 bit each: the ID instruction writes a register, or is a load.
REQ-008 The module SHALL have port DC_stall, input, 1 bit: L1 data-cache miss, which freezes the whole pipeline.
REQ-009 The module SHALL have ports ForwardA and ForwardB, output reg, 2 bits each: EX operand select, with 00 = register-file data, 01 = WB_out, 10 = MEM_ALUout.
REQ-010 The module SHALL have ports PC_Write and IFID_Write, output, 1 bit each: 0 holds the PC and the IF/ID register.
REQ-011 The module SHALL have port ID_flush, output, 1 bit: 1 inserts a bubble into ID/EX.

Function
REQ-012 The unit SHALL keep shadow slots EX, MEM and WB, each holding {valid, RegWrite, MemRead, Rd}, mirroring the datapath ID/EX, EX/MEM and MEM/WB registers.
REQ-013 A slot SHALL match register r only when valid=1, RegWrite=1, Rd==r and Rd!=0.
REQ-014 Load-use hazard SHALL be defined as: slot EX matches and has MemRead=1, and the match is against ID_Rs with ID_UseRs=1 or against ID_Rt with ID_UseRt=1.
REQ-015 PC_Write and IFID_Write SHALL be the combinational value ~(DC_stall | load-use hazard).
REQ-016 ID_flush SHALL be the combinational value load-use hazard & ~DC_stall.
REQ-017 On a clock edge with DC_stall=1, all slots and ForwardA/ForwardB SHALL hold their values.
REQ-018 On a clock edge with DC_stall=0, slots SHALL shift: MEM moves to WB and EX moves to MEM.
REQ-019 On the same advancing edge, EX SHALL load {~ID_flush, ID_RegWrite, ID_MemRead, ID_Rd}, so a bubble enters EX invalid.
REQ-020 On an advancing edge, ForwardA SHALL register, for ID_Rs: 10 if the EX slot matches and is not a load; else 01 if the MEM slot matches; else 00.
REQ-021 ForwardB SHALL be computed identically to ForwardA but for ID_Rt.
REQ-022 When ID_flush=1, ForwardA and ForwardB SHALL register 00.
REQ-023 ForwardA and ForwardB SHALL never take the value 11.
REQ-024 When both the EX and MEM slots match, the EX (younger) slot SHALL win.
REQ-025 A load-use hazard SHALL last exactly one stall cycle; on the next edge the load occupies MEM, so the dependent instruction forwards 01.
REQ-026 DC_stall asserted during a load-use stall SHALL take priority: the pipeline freezes, ID_flush=0, and the hazard is re-evaluated after DC_stall deasserts.

Reset
REQ-027 While rst=0, all slot valid bits SHALL be 0 and ForwardA=ForwardB=00.
REQ-028 While rst=0, PC_Write=IFID_Write=1 and ID_flush=0, because there are no valid slots and DC_stall is ignored.
REQ-029 On rst assertion mid-operation, all slots SHALL be cleared immediately, without waiting for a clock edge.

Configuration
REQ-030 With macro FORWARD_PATH_EN defined, forwarding SHALL operate as specified in REQ-020 to REQ-025.
REQ-031 With FORWARD_PATH_EN undefined, ForwardA and ForwardB SHALL be constant 00.
REQ-032 With FORWARD_PATH_EN undefined, the hazard term in REQ-015 and REQ-016 SHALL become "EX or MEM slot matches a used source", regardless of MemRead, and the register file is taken as write-before-read for WB.

Verification
REQ-033 The bench SHALL drive add $3 then add $4,$3,$5 with no stalls and check ForwardA=10 registered for the second instruction, with PC_Write held at 1.
REQ-034 The bench SHALL drive add $3, an unrelated instruction, then sub $6,$2,$3 with UseRt=1 and check ForwardB=01 and ForwardA=00.
REQ-035 The bench SHALL drive lw $7 then and $8,$7,$7 and check one cycle with PC_Write=IFID_Write=0 and ID_flush=1, followed by ForwardA=ForwardB=01.
REQ-036 The bench SHALL hold DC_stall=1 for 5 cycles during a load-use stall and check that outputs and slots freeze, ID_flush=0, and exactly one bubble is inserted after release.
REQ-037 The bench SHALL drive a write to $0 followed by a reader of $0 and check Forward=00 with no stall; a reset pulse mid-stream SHALL clear all stalls asynchronously.
REQ-038 With FORWARD_PATH_EN undefined, the bench SHALL drive add $3 then add $4,$3,$1 and check 2 stall cycles followed by Forward=00.
